// File: rtl/led_controller_if.sv
// Shared parameters, register map and the bus/global interfaces used by the LED controller.
package led_driver_pkg;
  parameter int DATA_BITS = 8;
  parameter int ADDR_BITS = 4;

  typedef enum logic [ADDR_BITS-1:0] {
    REG_PWM0   = 4'h2,
    REG_PWM1   = 4'h3,
    REG_PWM2   = 4'h4,
    REG_PWM3   = 4'h5,
    REG_GRPPWM = 4'h6,
    REG_LEDOUT = 4'h8
  } reg_enum_t;
endpackage

interface bus_if (
  input logic clk
);
  import led_driver_pkg::*;

  logic [ADDR_BITS-1:0] addr;
  wire  [DATA_BITS-1:0] data;
  logic                 w_en;
  logic                 r_en;

  // Host side drives addr/w_en/r_en; data is shared and tri-stated by whoever is not talking.
  modport led_ctrl (
    input clk,
    input addr,
    inout data,
    input w_en,
    input r_en
  );
endinterface

interface global_if;
  logic reset;
  logic sleep;

  modport led_ctrl (
    input reset,
    input sleep
  );
endinterface

// File: rtl/led_controller.sv
// Four-channel LED PWM controller with PCA9632-style PWM, group duty and LEDOUT mode registers.
module led_controller
  import led_driver_pkg::*;
(
  input logic        clk_400K,
  global_if.led_ctrl glb,
  bus_if.led_ctrl    bus,
  output logic [3:0] leds
);

  logic [3:0][DATA_BITS-1:0] pwm_q, pwm_d;
  logic [DATA_BITS-1:0]      grppwm_q, grppwm_d;
  logic [DATA_BITS-1:0]      ledout_q, ledout_d;
  logic [7:0]                pcnt_q, pcnt_d;
  logic [7:0]                gcnt_q, gcnt_d;
  logic [3:0]                leds_q, leds_d;

  logic [3:0]                pwm_sig;
  logic                      grp_sig;
  logic                      drive_en;
  logic [DATA_BITS-1:0]      rd_data;

  // Register write decode; unmapped addresses fall through untouched.
  always_comb begin
    pwm_d    = pwm_q;
    grppwm_d = grppwm_q;
    ledout_d = ledout_q;
    if (bus.w_en) begin
      case (bus.addr)
        REG_PWM0:   pwm_d[0] = bus.data;
        REG_PWM1:   pwm_d[1] = bus.data;
        REG_PWM2:   pwm_d[2] = bus.data;
        REG_PWM3:   pwm_d[3] = bus.data;
        REG_GRPPWM: grppwm_d = bus.data;
        REG_LEDOUT: ledout_d = bus.data;
        default: ;
      endcase
    end
  end

  // Counters freeze during sleep so PWM picks up exactly where it left off.
  always_comb begin
    pcnt_d = pcnt_q;
    gcnt_d = gcnt_q;
    if (!glb.sleep) begin
      pcnt_d = pcnt_q + 8'd1;
      if (pcnt_q == 8'hFF) begin
        gcnt_d = gcnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    grp_sig = (gcnt_q < grppwm_q);
    pwm_sig = '0;
    leds_d  = '0;
    for (int i = 0; i < 4; i++) begin
      pwm_sig[i] = (pcnt_q < pwm_q[i]);
      case (ledout_q[2*i +: 2])
        2'b00:   leds_d[i] = 1'b0;
        2'b01:   leds_d[i] = 1'b1;
        2'b10:   leds_d[i] = pwm_sig[i];
        default: leds_d[i] = pwm_sig[i] & grp_sig;
      endcase
    end
    if (glb.sleep) begin
      leds_d = '0;
    end
  end

  always_ff @(posedge clk_400K) begin
    if (glb.reset) begin
      pwm_q    <= '0;
      grppwm_q <= '1;
      ledout_q <= '0;
      pcnt_q   <= '0;
      gcnt_q   <= '0;
      leds_q   <= '0;
    end else begin
      pwm_q    <= pwm_d;
      grppwm_q <= grppwm_d;
      ledout_q <= ledout_d;
      pcnt_q   <= pcnt_d;
      gcnt_q   <= gcnt_d;
      leds_q   <= leds_d;
    end
  end

  // A simultaneous write owns the bus, so reads only drive when w_en is low.
  always_comb begin
    drive_en = bus.r_en & ~bus.w_en;
    rd_data  = '0;
    case (bus.addr)
      REG_PWM0:   rd_data = pwm_q[0];
      REG_PWM1:   rd_data = pwm_q[1];
      REG_PWM2:   rd_data = pwm_q[2];
      REG_PWM3:   rd_data = pwm_q[3];
      REG_GRPPWM: rd_data = grppwm_q;
      REG_LEDOUT: rd_data = ledout_q;
      default:    rd_data = '0;
    endcase
  end

  assign bus.data = drive_en ? rd_data : 'z;
  assign leds     = leds_q;

endmodule

// File: tb/tb_led_controller.sv
// Directed bench for led_controller: register access, LED modes, group gating, sleep and reset.
`timescale 1ns/1ps
module tb_led_controller;
  import led_driver_pkg::*;

  logic clk_400K = 1'b0;
  always #1250 clk_400K = ~clk_400K;

  bus_if    bus (.clk(clk_400K));
  global_if glb ();

  logic       host_oe;
  logic [7:0] host_data;
  logic [3:0] leds;

  assign bus.data = host_oe ? host_data : 'z;

  led_controller dut (
    .clk_400K (clk_400K),
    .glb      (glb),
    .bus      (bus),
    .leds     (leds)
  );

  int vectors     = 0;
  int miscompares = 0;
  int hi_cnt[4];

  // Reference {gcnt, pcnt}: cleared by reset, advanced every unslept clock.
  logic [15:0] m_cnt;
  always @(posedge clk_400K) begin
    if (glb.reset)       m_cnt <= '0;
    else if (!glb.sleep) m_cnt <= m_cnt + 16'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk_400K);
    bus.addr  = a;
    host_data = d;
    host_oe   = 1'b1;
    bus.w_en  = 1'b1;
    @(negedge clk_400K);
    bus.w_en  = 1'b0;
    host_oe   = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
    @(negedge clk_400K);
    bus.addr = a;
    bus.r_en = 1'b1;
    #1;
    check(tag, {24'd0, bus.data}, {24'd0, exp});
    bus.r_en = 1'b0;
  endtask

  task automatic measure();
    for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
    repeat (256) begin
      @(negedge clk_400K);
      for (int i = 0; i < 4; i++) if (leds[i]) hi_cnt[i]++;
    end
  endtask

  task automatic check_hi(input string tag, input int e0, input int e1, input int e2, input int e3);
    check({tag, "_ch0"}, hi_cnt[0], e0);
    check({tag, "_ch1"}, hi_cnt[1], e1);
    check({tag, "_ch2"}, hi_cnt[2], e2);
    check({tag, "_ch3"}, hi_cnt[3], e3);
  endtask

  task automatic wait_cnt(input logic [15:0] t);
    int guard;
    guard = 0;
    while (m_cnt !== t && guard < 70000) begin
      @(negedge clk_400K);
      guard++;
    end
    if (guard >= 70000) begin
      miscompares++;
      $error("FAIL wait_cnt timeout observed=%0h expected=%0h", m_cnt, t);
    end
  endtask

  initial begin
    logic [15:0] target;
    int          sleep_lit;

    glb.reset = 1'b1;
    glb.sleep = 1'b0;
    bus.addr  = '0;
    bus.w_en  = 1'b0;
    bus.r_en  = 1'b0;
    host_oe   = 1'b0;
    host_data = '0;
    repeat (3) @(negedge clk_400K);
    glb.reset = 1'b0;

    check("reset_leds", {28'd0, leds}, 32'h0);
    read_check("reset_pwm0", REG_PWM0, 8'h00);
    read_check("reset_pwm1", REG_PWM1, 8'h00);
    read_check("reset_pwm2", REG_PWM2, 8'h00);
    read_check("reset_pwm3", REG_PWM3, 8'h00);
    read_check("reset_grppwm", REG_GRPPWM, 8'hFF);
    read_check("reset_ledout", REG_LEDOUT, 8'h00);

    bus_write(REG_PWM0, 8'h40);
    bus_write(REG_PWM1, 8'h80);
    bus_write(REG_PWM2, 8'hC0);
    bus_write(REG_PWM3, 8'hFF);
    read_check("rb_pwm0", REG_PWM0, 8'h40);
    read_check("rb_pwm1", REG_PWM1, 8'h80);
    read_check("rb_pwm2", REG_PWM2, 8'hC0);
    read_check("rb_pwm3", REG_PWM3, 8'hFF);

    bus_write(4'h7, 8'h5A);
    bus_write(4'h1, 8'hA5);
    read_check("unmapped_7", 4'h7, 8'h00);
    read_check("unmapped_1", 4'h1, 8'h00);
    read_check("unmapped_keep_pwm0", REG_PWM0, 8'h40);
    read_check("unmapped_keep_pwm3", REG_PWM3, 8'hFF);
    read_check("unmapped_keep_grp", REG_GRPPWM, 8'hFF);
    read_check("unmapped_keep_ledout", REG_LEDOUT, 8'h00);

    @(negedge clk_400K);
    bus.addr  = REG_GRPPWM;
    host_data = 8'hC0;
    host_oe   = 1'b1;
    bus.w_en  = 1'b1;
    bus.r_en  = 1'b1;
    @(negedge clk_400K);
    bus.w_en  = 1'b0;
    bus.r_en  = 1'b0;
    host_oe   = 1'b0;
    read_check("wr_and_rd_write", REG_GRPPWM, 8'hC0);
    bus_write(REG_GRPPWM, 8'hFF);

    bus_write(REG_LEDOUT, 8'h55);
    @(negedge clk_400K);
    check("mode01_a", {28'd0, leds}, 32'hF);
    repeat (100) @(negedge clk_400K);
    check("mode01_b", {28'd0, leds}, 32'hF);

    bus_write(REG_LEDOUT, 8'hAA);
    @(negedge clk_400K);
    measure();
    check_hi("mode10", 64, 128, 192, 255);

    bus_write(REG_LEDOUT, 8'h1B);
    @(negedge clk_400K);
    measure();
    check_hi("mixed", 64, 128, 256, 0);

    bus_write(REG_GRPPWM, 8'hC0);
    bus_write(REG_LEDOUT, 8'hFF);
    @(negedge clk_400K);
    measure();
    check_hi("grp_c0_early", 64, 128, 192, 255);

    bus_write(REG_GRPPWM, 8'h00);
    @(negedge clk_400K);
    measure();
    check_hi("grp_00", 0, 0, 0, 0);

    bus_write(REG_GRPPWM, 8'h20);
    wait_cnt(16'h1F00);
    measure();
    check_hi("grp_20_gcnt31", 64, 128, 192, 255);
    measure();
    check_hi("grp_20_gcnt32", 0, 0, 0, 0);

    bus_write(REG_GRPPWM, 8'hC0);
    wait_cnt(16'hBF00);
    measure();
    check_hi("grp_c0_gcntbf", 64, 128, 192, 255);
    measure();
    check_hi("grp_c0_gcntc0", 0, 0, 0, 0);

    bus_write(REG_LEDOUT, 8'hAA);
    target = {m_cnt[15:8] + 8'd1, 8'h7C};
    wait_cnt(target);
    glb.sleep = 1'b1;
    sleep_lit = 0;
    repeat (40) begin
      @(negedge clk_400K);
      if (leds != 4'b0000) sleep_lit++;
    end
    check("sleep_leds_dark", sleep_lit, 0);
    read_check("sleep_read_pwm1", REG_PWM1, 8'h80);
    glb.sleep = 1'b0;
    @(negedge clk_400K);
    check("resume_pcnt7c", {28'd0, leds}, 32'hE);
    repeat (3) @(negedge clk_400K);
    @(negedge clk_400K);
    check("resume_pcnt80", {28'd0, leds}, 32'hC);

    @(negedge clk_400K);
    glb.reset = 1'b1;
    bus.addr  = REG_PWM0;
    host_data = 8'h77;
    host_oe   = 1'b1;
    bus.w_en  = 1'b1;
    @(negedge clk_400K);
    glb.reset = 1'b0;
    bus.w_en  = 1'b0;
    host_oe   = 1'b0;
    check("rst2_leds", {28'd0, leds}, 32'h0);
    read_check("rst2_pwm0", REG_PWM0, 8'h00);
    read_check("rst2_pwm1", REG_PWM1, 8'h00);
    read_check("rst2_pwm2", REG_PWM2, 8'h00);
    read_check("rst2_pwm3", REG_PWM3, 8'h00);
    read_check("rst2_grppwm", REG_GRPPWM, 8'hFF);
    read_check("rst2_ledout", REG_LEDOUT, 8'h00);
    measure();
    check_hi("rst2_dark", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
